pc_stack_unit: RTL and testbench

Program-counter stage that sits directly upstream of instruction memory and feeds the opcode path consumed by the control unit (uc).
- Holds the PC and selects next PC from three sources: sequential (PC+1), absolute jump target, or return address.
- Includes a hardware return-address stack (LIFO) so the processor can execute CALL/RET.
- Driven by the control unit's s_inc select plus call/ret strobes decoded from the opcode.

---
 rtl/proc_pkg.sv | 13 +
 rtl/ras_lifo.sv | 105 ++++++++++
 rtl/pc_stack_unit.sv | 90 +++++++++
 tb/tb_pc_stack_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the program-counter stage: PC width, reset vector and
// the next-PC source encoding used by the PC mux.
`timescale 1ns/1ps
package proc_pkg;

    localparam int PC_W     = 10;
    localparam int RESET_PC = 0;

    localparam logic [1:0] NPC_INC = 2'd0;
    localparam logic [1:0] NPC_JMP = 2'd1;
    localparam logic [1:0] NPC_RET = 2'd2;

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack: DEPTH x PC_W register file with push/pop, occupancy
// and sticky over/underflow flags. PC_STACK_CIRC_EN makes a full push overwrite the oldest entry.
`timescale 1ns/1ps
module ras_lifo #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 4,
    parameter int SP_W  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            unf
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Entries live at base+k (k=0 oldest); base only moves in circular mode.
`ifdef PC_STACK_CIRC_EN
    logic [IDX_W-1:0] base_q, base_d;
    assign base = base_q;
`else
    assign base = '0;
`endif

    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);
    assign sp     = sp_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

    // When full, the low sp bits are zero, so wr_idx lands on the oldest slot.
    assign wr_idx   = base + sp_q[IDX_W-1:0];
    assign rd_idx   = base + sp_q[IDX_W-1:0] - IDX_W'(1);
    assign top_data = mem_q[rd_idx];

    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        wr_en = 1'b0;
`ifdef PC_STACK_CIRC_EN
        base_d = base_q;
`endif
        if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d = sp_q - SP_W'(1);
            end
        end else if (push) begin
            if (!full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + SP_W'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef PC_STACK_CIRC_EN
                wr_en  = 1'b1;
                base_d = base_q + IDX_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifdef PC_STACK_CIRC_EN
            base_q <= '0;
`endif
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
`ifdef PC_STACK_CIRC_EN
            base_q <= base_d;
`endif
        end
    end

    // Stack storage carries no reset; stale entries are unreachable once sp clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with next-PC mux (PC+1 / jump / return) and a hardware
// return-address stack. Define PC_STACK_CIRC_EN for a circular stack.
`timescale 1ns/1ps
module pc_stack_unit #(
    parameter int PC_W  = proc_pkg::PC_W,
    parameter int DEPTH = 4,
    parameter int SP_W  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_inc,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [SP_W-1:0] sp,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            ovf,
    output logic            unf
);

    import proc_pkg::*;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ras_top;
    logic [1:0]      npc_sel;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_empty;

    assign pc_inc   = pc_q + PC_W'(1);
    assign ras_pop  = ret;
    // ret dominates: a simultaneous call neither pushes nor flags overflow.
    assign ras_push = call & ~ret;

    always_comb begin
        npc_sel = NPC_INC;
        if (ret) begin
            npc_sel = ras_empty ? NPC_INC : NPC_RET;
        end else if (call) begin
            npc_sel = NPC_JMP;
        end else if (s_inc) begin
            npc_sel = NPC_INC;
        end else begin
            npc_sel = NPC_JMP;
        end
    end

    always_comb begin
        pc_d = pc_inc;
        case (npc_sel)
            NPC_INC: pc_d = pc_inc;
            NPC_JMP: pc_d = jmp_addr;
            NPC_RET: pc_d = ras_top;
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    ras_lifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .SP_W  (SP_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (ras_empty),
        .ovf       (ovf),
        .unf       (unf)
    );

    assign pc          = pc_q;
    assign stack_empty = ras_empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed testbench for pc_stack_unit; expectations follow PC_STACK_CIRC_EN when defined.
`timescale 1ns/1ps
module tb_pc_stack_unit;

    localparam int PC_W = 10;
    localparam int SP_W = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_inc;
    logic [PC_W-1:0] jmp_addr;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic            stack_empty;
    logic            stack_full;
    logic            ovf;
    logic            unf;

    int checks = 0;
    int errors = 0;

    pc_stack_unit #(.PC_W(PC_W), .DEPTH(4), .SP_W(SP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_inc       (s_inc),
        .jmp_addr    (jmp_addr),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .sp          (sp),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one set of strobes, clock it, and sample 1 ns after the edge.
    task automatic drive(input logic s, input logic c, input logic r, input logic [PC_W-1:0] j);
        s_inc = s; call = c; ret = r; jmp_addr = j;
        @(posedge clk);
        #1;
        $display("tx s_inc=%0b call=%0b ret=%0b jmp=%h -> pc=%h sp=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 s, c, r, j, pc, sp, stack_full, stack_empty, ovf, unf);
    endtask

    task automatic test_reset();
        reset = 1'b1; s_inc = 1'b1; call = 1'b0; ret = 1'b0; jmp_addr = '0;
        @(posedge clk);
        #1;
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 10'h000); end
        checks++; if (sp !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", sp); end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1 0", stack_empty, stack_full); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_sticky got ovf=%b unf=%b exp 0 0", ovf, unf); end
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        checks++; if (pc !== 10'h001) begin errors++; $display("FAIL release_pc got %h exp %h", pc, 10'h001); end
        // Build up state: underflow, two calls, then jump to 0x023.
        drive(1'b1, 1'b0, 1'b1, 10'h000);
        checks++; if (pc !== 10'h002 || unf !== 1'b1) begin errors++; $display("FAIL pre_unf got pc=%h unf=%b exp 002 1", pc, unf); end
        drive(1'b1, 1'b1, 1'b0, 10'h100);
        drive(1'b1, 1'b1, 1'b0, 10'h200);
        drive(1'b0, 1'b0, 1'b0, 10'h023);
        checks++; if (pc !== 10'h023 || sp !== 3'd2) begin errors++; $display("FAIL pre_reset_state got pc=%h sp=%0d exp 023 2", pc, sp); end
        reset = 1'b1;
        #1;
        checks++; if (pc !== 10'h000 || sp !== 3'd0) begin errors++; $display("FAIL midrun_reset got pc=%h sp=%0d exp 000 0", pc, sp); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0 || stack_empty !== 1'b1) begin errors++; $display("FAIL midrun_flags got ovf=%b unf=%b empty=%b exp 0 0 1", ovf, unf, stack_empty); end
        #4;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        checks++; if (pc !== 10'h001) begin errors++; $display("FAIL midrun_release_pc got %h exp %h", pc, 10'h001); end
    endtask

    task automatic test_seq_jump();
        logic [PC_W-1:0] exp_seq [3];
        exp_seq[0] = 10'h002; exp_seq[1] = 10'h003; exp_seq[2] = 10'h004;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 10'h3AB);
            checks++; if (pc !== exp_seq[i]) begin errors++; $display("FAIL seq_%0d got %h exp %h", i, pc, exp_seq[i]); end
        end
        drive(1'b0, 1'b0, 1'b0, 10'h150);
        checks++; if (pc !== 10'h150) begin errors++; $display("FAIL jump_pc got %h exp %h", pc, 10'h150); end
        drive(1'b0, 1'b0, 1'b0, 10'h3FF);
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 10'h000); end
    endtask

    task automatic test_call_ret();
        drive(1'b0, 1'b0, 1'b0, 10'h010);
        drive(1'b1, 1'b1, 1'b0, 10'h200);
        checks++; if (pc !== 10'h200 || sp !== 3'd1) begin errors++; $display("FAIL call_state got pc=%h sp=%0d exp 200 1", pc, sp); end
        checks++; if (stack_empty !== 1'b0) begin errors++; $display("FAIL call_empty got %b exp 0", stack_empty); end
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        checks++; if (pc !== 10'h202) begin errors++; $display("FAIL callee_inc got %h exp %h", pc, 10'h202); end
        drive(1'b1, 1'b0, 1'b1, 10'h000);
        checks++; if (pc !== 10'h011 || sp !== 3'd0 || stack_empty !== 1'b1) begin errors++; $display("FAIL ret_state got pc=%h sp=%0d empty=%b exp 011 0 1", pc, sp, stack_empty); end
        // Return address wraps: call from 0x3FF pushes 0x000.
        drive(1'b0, 1'b0, 1'b0, 10'h3FF);
        drive(1'b1, 1'b1, 1'b0, 10'h055);
        drive(1'b1, 1'b0, 1'b1, 10'h000);
        checks++; if (pc !== 10'h000 || sp !== 3'd0) begin errors++; $display("FAIL wrap_ret got pc=%h sp=%0d exp 000 0", pc, sp); end
        // Call immediately followed by ret.
        drive(1'b0, 1'b0, 1'b0, 10'h030);
        drive(1'b1, 1'b1, 1'b0, 10'h300);
        drive(1'b1, 1'b0, 1'b1, 10'h000);
        checks++; if (pc !== 10'h031 || unf !== 1'b0) begin errors++; $display("FAIL call_ret_b2b got pc=%h unf=%b exp 031 0", pc, unf); end
    endtask

    task automatic test_overflow();
        logic [PC_W-1:0] tgt  [5];
        logic [PC_W-1:0] rets [4];
        logic [PC_W-1:0] last_ret;
        tgt[0] = 10'h101; tgt[1] = 10'h201; tgt[2] = 10'h301; tgt[3] = 10'h381; tgt[4] = 10'h3C0;
`ifdef PC_STACK_CIRC_EN
        rets[0] = 10'h382; rets[1] = 10'h302; rets[2] = 10'h202; rets[3] = 10'h102;
`else
        rets[0] = 10'h302; rets[1] = 10'h202; rets[2] = 10'h102; rets[3] = 10'h002;
`endif
        drive(1'b0, 1'b0, 1'b0, 10'h001);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, tgt[i]);
        end
        checks++; if (sp !== 3'd4 || stack_full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL four_calls got sp=%0d full=%b ovf=%b exp 4 1 0", sp, stack_full, ovf); end
        drive(1'b1, 1'b1, 1'b0, tgt[4]);
        checks++; if (pc !== 10'h3C0 || sp !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL fifth_call got pc=%h sp=%0d ovf=%b exp 3c0 4 1", pc, sp, ovf); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 10'h000);
            checks++; if (pc !== rets[i] || sp !== SP_W'(3 - i)) begin errors++; $display("FAIL ovf_ret_%0d got pc=%h sp=%0d exp %h %0d", i, pc, sp, rets[i], 3 - i); end
        end
        checks++; if (unf !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL drained_flags got unf=%b ovf=%b exp 0 1", unf, ovf); end
        last_ret = rets[3] + 10'h001;
        drive(1'b1, 1'b0, 1'b1, 10'h000);
        checks++; if (pc !== last_ret || unf !== 1'b1 || sp !== 3'd0) begin errors++; $display("FAIL lost_ret got pc=%h unf=%b sp=%0d exp %h 1 0", pc, unf, sp, last_ret); end
    endtask

    task automatic test_underflow_conflict();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'h040);
        drive(1'b1, 1'b0, 1'b1, 10'h000);
        checks++; if (pc !== 10'h041 || unf !== 1'b1 || sp !== 3'd0) begin errors++; $display("FAIL underflow got pc=%h unf=%b sp=%0d exp 041 1 0", pc, unf, sp); end
        drive(1'b0, 1'b0, 1'b0, 10'h0A9);
        drive(1'b1, 1'b1, 1'b0, 10'h123);
        drive(1'b1, 1'b1, 1'b1, 10'h2EE);
        checks++; if (pc !== 10'h0AA || sp !== 3'd0 || ovf !== 1'b0) begin errors++; $display("FAIL conflict got pc=%h sp=%0d ovf=%b exp 0aa 0 0", pc, sp, ovf); end
        // Conflict on an empty stack takes the underflow path with no push.
        drive(1'b0, 1'b1, 1'b1, 10'h2EE);
        checks++; if (pc !== 10'h0AB || sp !== 3'd0 || stack_empty !== 1'b1) begin errors++; $display("FAIL conflict_empty got pc=%h sp=%0d empty=%b exp 0ab 0 1", pc, sp, stack_empty); end
    endtask

    initial begin
        test_reset();
        test_seq_jump();
        test_call_ret();
        test_overflow();
        test_underflow_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
